// File: rtl/MD_pkg.sv
// Shared packet geometry for the MD force pipeline: force triple, particle ID and three cell IDs.
package MD_pkg;
  localparam int FLOAT_WIDTH          = 32;
  localparam int FLOAT_STRUCT_WIDTH   = 3 * FLOAT_WIDTH;
  localparam int PARTICLE_ID_WIDTH    = 12;
  localparam int CELL_ID_WIDTH        = 3;
  localparam int FRC_PKT_STRUCT_WIDTH = FLOAT_STRUCT_WIDTH + PARTICLE_ID_WIDTH + 3 * CELL_ID_WIDTH;
endpackage

// File: rtl/nb_frc_release_fifo.sv
// Force-release FIFO between the non-bonded force units and the force return path.
// Optional statistics counters are built when NB_FRC_FIFO_STATS_EN is defined.
module nb_frc_release_fifo
  import MD_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            nb_frc_release_valid,
  input  logic [FRC_PKT_STRUCT_WIDTH-1:0] nb_frc_release,
  output logic                            frc_out_valid,
  input  logic                            frc_out_ready,
  output logic [FRC_PKT_STRUCT_WIDTH-1:0] frc_out,
  output logic                            nb_frc_afull,
  output logic [$clog2(DEPTH):0]          occupancy,
  output logic                            overflow,
  output logic [31:0]                     pkt_in_cnt,
  output logic [31:0]                     drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = FRC_PKT_STRUCT_WIDTH;

  logic [PW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_next_s, rd_ptr_next_s;
  logic [CW-1:0] count_r, count_next_s, count_after_pop_s;
  logic          push_s, pop_s, drop_s;
  logic          valid_r, afull_r, overflow_r;
  logic [PW-1:0] head_r, head_next_s;

  // Handshake decode, pointer/occupancy update and next head selection.
  always_comb begin
    pop_s             = valid_r & frc_out_ready;
    push_s            = nb_frc_release_valid & ((count_r < CW'(DEPTH)) | pop_s);
    drop_s            = nb_frc_release_valid & ~push_s;
    wr_ptr_next_s     = push_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
    rd_ptr_next_s     = pop_s  ? rd_ptr_r + AW'(1) : rd_ptr_r;
    count_after_pop_s = count_r - CW'(pop_s);
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
    // An empty FIFO after the pop means the head is the packet being written now.
    if (count_next_s == {CW{1'b0}}) begin
      head_next_s = {PW{1'b0}};
    end else if (count_after_pop_s == {CW{1'b0}}) begin
      head_next_s = nb_frc_release;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // Packet storage; contents survive reset since the pointers discard them.
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      mem_r[wr_ptr_r] <= nb_frc_release;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      valid_r    <= 1'b0;
      afull_r    <= 1'b0;
      overflow_r <= 1'b0;
      head_r     <= {PW{1'b0}};
    end else begin
      wr_ptr_r   <= wr_ptr_next_s;
      rd_ptr_r   <= rd_ptr_next_s;
      count_r    <= count_next_s;
      valid_r    <= (count_next_s != {CW{1'b0}});
      afull_r    <= (count_next_s >= CW'(AFULL_THRESH));
      overflow_r <= overflow_r | drop_s;
      head_r     <= head_next_s;
    end
  end

  assign frc_out_valid = valid_r;
  assign frc_out       = head_r;
  assign nb_frc_afull  = afull_r;
  assign occupancy     = count_r;
  assign overflow      = overflow_r;

`ifdef NB_FRC_FIFO_STATS_EN
  logic [31:0] pkt_in_cnt_r, drop_cnt_r;

  // Saturating accepted/dropped packet counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pkt_in_cnt_r <= 32'h0000_0000;
      drop_cnt_r   <= 32'h0000_0000;
    end else begin
      if (push_s && (pkt_in_cnt_r != 32'hFFFF_FFFF)) begin
        pkt_in_cnt_r <= pkt_in_cnt_r + 32'd1;
      end else begin
        pkt_in_cnt_r <= pkt_in_cnt_r;
      end
      if (drop_s && (drop_cnt_r != 32'hFFFF_FFFF)) begin
        drop_cnt_r <= drop_cnt_r + 32'd1;
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  assign pkt_in_cnt = pkt_in_cnt_r;
  assign drop_cnt   = drop_cnt_r;
`else
  assign pkt_in_cnt = 32'h0000_0000;
  assign drop_cnt   = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_nb_frc_release_fifo.sv
// Scoreboard bench for nb_frc_release_fifo: a queue model predicts contents and flags,
// a negedge monitor checks every presented head packet against the expected order.
module tb_nb_frc_release_fifo;
  import MD_pkg::*;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;
  localparam int PW    = FRC_PKT_STRUCT_WIDTH;
  typedef logic [PW-1:0] pkt_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        nb_frc_release_valid = 1'b0;
  pkt_t        nb_frc_release = '0;
  logic        frc_out_valid;
  logic        frc_out_ready = 1'b0;
  pkt_t        frc_out;
  logic        nb_frc_afull;
  logic [4:0]  occupancy;
  logic        overflow;
  logic [31:0] pkt_in_cnt, drop_cnt;

  nb_frc_release_fifo #(.DEPTH(DEPTH), .AFULL_THRESH(AFULL)) dut (
    .clk(clk), .rst(rst),
    .nb_frc_release_valid(nb_frc_release_valid), .nb_frc_release(nb_frc_release),
    .frc_out_valid(frc_out_valid), .frc_out_ready(frc_out_ready), .frc_out(frc_out),
    .nb_frc_afull(nb_frc_afull), .occupancy(occupancy), .overflow(overflow),
    .pkt_in_cnt(pkt_in_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  pkt_t sb[$];
  int   mcount = 0;
  logic exp_ovf = 1'b0;
  int   exp_in = 0;
  int   exp_drop = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented head must equal the oldest expected packet.
  always @(negedge clk) begin
    if (rst && frc_out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_head: got %0h expected none", frc_out);
      end else begin
        chk("frc_out_head", 128'(frc_out), 128'(sb[0]));
        if (frc_out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic check_state();
    chk("occupancy", 128'(occupancy), 128'(mcount));
    chk("frc_out_valid", 128'(frc_out_valid), 128'(mcount != 0));
    chk("nb_frc_afull", 128'(nb_frc_afull), 128'(mcount >= AFULL));
    chk("overflow", 128'(overflow), 128'(exp_ovf));
    if (mcount == 0) chk("frc_out_zero", 128'(frc_out), 128'(0));
`ifdef NB_FRC_FIFO_STATS_EN
    chk("pkt_in_cnt", 128'(pkt_in_cnt), 128'(exp_in));
    chk("drop_cnt", 128'(drop_cnt), 128'(exp_drop));
`else
    chk("pkt_in_cnt_tied", 128'(pkt_in_cnt), 128'(0));
    chk("drop_cnt_tied", 128'(drop_cnt), 128'(0));
`endif
  endtask

  // One clock: drive inputs, predict with the queue model, then check after the edge.
  task automatic cycle(input logic v, input pkt_t p, input logic rdy);
    logic mpop, mpush;
    nb_frc_release_valid = v;
    nb_frc_release       = p;
    frc_out_ready        = rdy;
    if (rst) begin
      mpop  = (mcount > 0) && rdy;
      mpush = v && ((mcount < DEPTH) || mpop);
      if (mpush) begin
        sb.push_back(p);
        exp_in++;
      end
      if (v && !mpush) begin
        exp_ovf = 1'b1;
        exp_drop++;
      end
      mcount = mcount + int'(mpush) - int'(mpop);
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      sb.delete();
      mcount = 0;
      exp_ovf = 1'b0;
      exp_in = 0;
      exp_drop = 0;
    end
    check_state();
  endtask

  function automatic pkt_t rnd_pkt();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[PW-1:0];
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    cycle(1'b1, rnd_pkt(), 1'b1);
    cycle(1'b1, rnd_pkt(), 1'b0);
    rst = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && mcount > 0; i++) cycle(1'b0, '0, 1'b1);
    chk("drain_model_empty", 128'(mcount), 128'(0));
    chk("drain_sb_empty", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    pkt_t a5;
    logic [127:0] a5_wide;
    int   guard;
    a5_wide = {16{8'hA5}};
    a5 = a5_wide[PW-1:0];

    do_reset();

    // Single packet through an idle FIFO.
    cycle(1'b1, a5, 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk("single_pop_empty", 128'(sb.size()), 128'(0));

    // Fill with no consumer, then overflow with one extra packet.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, rnd_pkt(), 1'b0);
    cycle(1'b1, rnd_pkt(), 1'b0);
    cycle(1'b0, '0, 1'b0);

    // Full FIFO with simultaneous push and pop.
    cycle(1'b1, rnd_pkt(), 1'b1);
    cycle(1'b1, rnd_pkt(), 1'b1);
    drain();

    // Forty packets with random back-pressure and gaps; pointers wrap.
    do_reset();
    guard = 0;
    while (exp_in < 40 && guard < 1000) begin
      cycle(($urandom_range(0, 4) != 0) && (mcount < DEPTH) && (exp_in < 40),
            rnd_pkt(), $urandom_range(0, 3) != 0);
      guard++;
    end
    chk("forty_pushed", 128'(exp_in), 128'(40));
    drain();

    // Reset while five packets are held.
    for (int i = 0; i < 5; i++) cycle(1'b1, rnd_pkt(), 1'b0);
    rst = 1'b0;
    cycle(1'b1, rnd_pkt(), 1'b0);
    chk("reset_occ", 128'(occupancy), 128'(0));
    rst = 1'b1;
    cycle(1'b1, a5, 1'b0);
    cycle(1'b0, '0, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
